// File: rtl/ifetch_pkg.sv
// Shared opcodes, state encoding and decode helpers for the instruction fetch unit.
package ifetch_pkg;

  localparam logic [6:0]  OPC_HALT     = 7'b1010101;
  localparam logic [6:0]  OPC_RTYPE    = 7'b0110011;
  localparam logic [6:0]  OPC_LOAD_IMM = 7'b1111111;
  localparam logic [31:0] NOP_WORD     = 32'h0000_0000;
  localparam int          CNT_W        = 16;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } ifetch_state_e;

  function automatic logic is_halt(input logic [6:0] opc);
    return (opc == OPC_HALT);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// 16-bit event counter that sticks at all-ones instead of wrapping.
module sat_counter
  import ifetch_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  // count register, frozen once saturated
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= {CNT_W{1'b0}};
    end else if (en && (count != {CNT_W{1'b1}})) begin
      count <= count + CNT_W'(1'b1);
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch-side initiator: owns the PC, replays on decode stalls, squashes on redirect, stops on HALT.
// Optional transfer/stall counters are built when IFETCH_PERF_CNT_EN is defined.
module instruction_fetch
  import ifetch_pkg::*;
#(
  parameter int                ADDR_W   = 5,
  parameter int                INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
  input  logic               clk,
  input  logic               reset,
  output logic [ADDR_W-1:0]  prog_addr,
  input  logic [INSTR_W-1:0] instruction,
  output logic [INSTR_W-1:0] instr_out,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               halted
`ifdef IFETCH_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]   fetch_count,
  output logic [CNT_W-1:0]   stall_count
`endif
);

  ifetch_state_e     state_r, state_nxt_s;
  logic [ADDR_W-1:0] fetch_pc_r, fetch_pc_nxt_s;
  logic [ADDR_W-1:0] resp_pc_r;
  logic [ADDR_W-1:0] addr_s;
  logic              resp_valid_r, resp_valid_nxt_s;
  logic              run_s, issue_s, stall_s, xfer_s, halt_take_s;

  assign run_s       = (state_r == RUN);
  assign issue_s     = run_s | redirect_valid;
  assign instr_valid = resp_valid_r & ~redirect_valid & run_s;
  assign stall_s     = instr_valid & ~instr_ready;
  assign xfer_s      = instr_valid & instr_ready;
  assign halt_take_s = xfer_s & is_halt(instruction[6:0]);

  // address select and next-state; redirect beats stall beats HALT beats sequential
  always_comb begin
    addr_s           = fetch_pc_r;
    fetch_pc_nxt_s   = fetch_pc_r;
    resp_valid_nxt_s = issue_s;
    state_nxt_s      = state_r;
    if (redirect_valid) begin
      addr_s         = redirect_pc;
      fetch_pc_nxt_s = redirect_pc + ADDR_W'(1'b1);
      state_nxt_s    = RUN;
    end else if (stall_s) begin
      addr_s         = resp_pc_r;
    end else if (halt_take_s) begin
      // word behind HALT is discarded and the address stays parked
      resp_valid_nxt_s = 1'b0;
      state_nxt_s      = HALTED;
    end else if (run_s) begin
      fetch_pc_nxt_s = fetch_pc_r + ADDR_W'(1'b1);
    end else begin
      fetch_pc_nxt_s = fetch_pc_r;
    end
  end

  // fetch state registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= RUN;
      fetch_pc_r   <= RESET_PC;
      resp_pc_r    <= {ADDR_W{1'b0}};
      resp_valid_r <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      fetch_pc_r   <= fetch_pc_nxt_s;
      resp_pc_r    <= addr_s;
      resp_valid_r <= resp_valid_nxt_s;
    end
  end

  assign prog_addr = addr_s;
  assign instr_out = instruction;
  assign instr_pc  = resp_pc_r;
  assign halted    = (state_r == HALTED);

`ifdef IFETCH_PERF_CNT_EN
  sat_counter u_fetch_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (xfer_s),
    .count (fetch_count)
  );

  sat_counter u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (stall_s),
    .count (stall_count)
  );
`endif

endmodule
